// File: rtl/sls_pkg.sv
// sls_pkg: access-size, FSM-state and R/W encodings shared by sls_mem_responder.
package sls_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_DWORD = 2'b11} size_e;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_DW_GAP, S_WAIT2, S_DONE2} state_e;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/sls_read_align.sv
// sls_read_align: picks the big-endian byte lanes for the access size and sign/zero-extends to 32 bits.
module sls_read_align
  import sls_pkg::*;
(
  input  size_e       size,
  input  logic        sext,
  input  logic [31:0] raw,
  output logic [31:0] data
);
  always_comb
    data = size == SZ_BYTE ? {{24{sext & raw[31]}}, raw[31:24]}
         : size == SZ_HALF ? {{16{sext & raw[31]}}, raw[31:16]}
         : raw;
endmodule

// File: rtl/sls_mem_responder.sv
// sls_mem_responder: MFA/MOC load/store responder over a big-endian byte RAM.
// Define SLS_ALIGN_CHECK_EN to flag misaligned accesses on ERR instead of clearing low address bits.
module sls_mem_responder
  import sls_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              MFA,
  input  logic              RW,
  input  logic              SIGN_EXT,
  input  logic [1:0]        SIZE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DATA_IN,
  output logic [31:0]       DATA_OUT,
  output logic              MOC,
  output logic              BEAT,
  output logic              ERR
);
  state_e            state_q, state_d;
  size_e             size_q, size_d;
  logic              rw_q, rw_d, sext_q, sext_d, moc_q, moc_d, beat_q, beat_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ea;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       dout_q, dout_d, raw, rd_data;
  logic              idle_start, start, waiting, commit, mis, we;
  logic [7:0]        mem [2**ADDR_W];

`ifdef SLS_ALIGN_CHECK_EN
  assign ea  = addr_q;
  assign mis = (size_q == SZ_HALF && addr_q[0]) || (size_q[1] && addr_q[1:0] != 2'b00);
`else
  assign ea  = size_q == SZ_HALF ? {addr_q[ADDR_W-1:1], 1'b0}
             : size_q[1] ? {addr_q[ADDR_W-1:2], 2'b00} : addr_q;
  assign mis = 1'b0;
`endif

  assign raw = {mem[ea], mem[ea + ADDR_W'(1)], mem[ea + ADDR_W'(2)], mem[ea + ADDR_W'(3)]};

  sls_read_align u_align (.size(size_q), .sext(sext_q), .raw(raw), .data(rd_data));

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= S_IDLE;
      size_q  <= SZ_BYTE;
      rw_q    <= 1'b0;
      sext_q  <= 1'b0;
      moc_q   <= 1'b0;
      beat_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      rw_q    <= rw_d;
      sext_q  <= sext_d;
      moc_q   <= moc_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (MFA) state_d = S_WAIT;
      S_WAIT:   if (!MFA) state_d = S_IDLE; else if (cnt_q == 4'd0) state_d = S_DONE;
      S_DONE:   if (!MFA) state_d = size_q == SZ_DWORD && !err_q ? S_DW_GAP : S_IDLE;
      S_DW_GAP: if (MFA) state_d = S_WAIT2;
      S_WAIT2:  if (!MFA) state_d = S_IDLE; else if (cnt_q == 4'd0) state_d = S_DONE2;
      S_DONE2:  if (!MFA) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    idle_start = MFA && state_q == S_IDLE;
    start      = idle_start || (MFA && state_q == S_DW_GAP);
    waiting    = MFA && (state_q == S_WAIT || state_q == S_WAIT2);
    commit     = waiting && cnt_q == 4'd0;
    we         = commit && rw_q == RW_WRITE && !mis;
    rw_d       = idle_start ? RW : rw_q;
    sext_d     = idle_start ? SIGN_EXT : sext_q;
    size_d     = idle_start ? size_e'(SIZE) : size_q;
    addr_d     = idle_start ? ADDR : MFA && state_q == S_DW_GAP ? addr_q + ADDR_W'(4) : addr_q;
    cnt_d      = start ? 4'(WAIT_STATES) : waiting && cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
    moc_d      = state_d == S_DONE || state_d == S_DONE2;
    beat_d     = state_d == S_DW_GAP || state_d == S_WAIT2 || state_d == S_DONE2;
    err_d      = commit ? mis : moc_d && err_q;
    dout_d     = commit && rw_q == RW_READ && !mis ? rd_data : dout_q;
  end

  // RAM has no reset; writes are gated by FSM state, which the async reset forces to IDLE
  always_ff @(posedge CLK)
    if (we) begin
      mem[ea] <= size_q == SZ_BYTE ? DATA_IN[7:0] : size_q == SZ_HALF ? DATA_IN[15:8] : DATA_IN[31:24];
      if (size_q != SZ_BYTE) mem[ea + ADDR_W'(1)] <= size_q == SZ_HALF ? DATA_IN[7:0] : DATA_IN[23:16];
      if (size_q[1]) begin
        mem[ea + ADDR_W'(2)] <= DATA_IN[15:8];
        mem[ea + ADDR_W'(3)] <= DATA_IN[7:0];
      end
    end

  assign DATA_OUT = dout_q;
  assign MOC      = moc_q;
  assign BEAT     = beat_q;
  assign ERR      = err_q;
endmodule

// File: tb/tb_sls_mem_responder.sv
// tb_sls_mem_responder: scoreboard bench with a byte-array reference model; follows SLS_ALIGN_CHECK_EN.
module tb_sls_mem_responder;
  localparam int AW = 9, WS = 2, DEPTH = 512;

  logic          CLK = 0, RST_N = 1, MFA = 0, RW = 0, SIGN_EXT = 0;
  logic [1:0]    SIZE = 0;
  logic [AW-1:0] ADDR = 0;
  logic [31:0]   DATA_IN = 0, DATA_OUT;
  logic          MOC, BEAT, ERR;

  sls_mem_responder #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
    .CLK(CLK), .RST_N(RST_N), .MFA(MFA), .RW(RW), .SIGN_EXT(SIGN_EXT), .SIZE(SIZE),
    .ADDR(ADDR), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .MOC(MOC), .BEAT(BEAT), .ERR(ERR));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {int cyc; logic [31:0] dout; logic err; logic beat;} exp_t;
  exp_t        sb[$];
  int          nvec = 0, nerr = 0;
  logic [7:0]  ref_mem[DEPTH];
  logic [31:0] exp_dout = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s @cycle %0d: got %h required %h", name, cyc, act, req);
    end
  endtask

  function automatic logic [31:0] mrd(int a, int n);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[(a + i) % DEPTH]);
    return v;
  endfunction

  function automatic void mwr(int a, int n, logic [31:0] d);
    for (int i = 0; i < n; i++) ref_mem[(a + i) % DEPTH] = 8'(d >> (8 * (n - 1 - i)));
  endfunction

  function automatic logic [31:0] model_read(int a, int n, logic sext);
    logic [31:0] v = mrd(a, n);
    if (sext && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // Monitor: every MOC rising edge must match the oldest outstanding expectation
  logic prev_moc = 0;
  always @(negedge CLK) begin
    exp_t e;
    if (MOC === 1'b1 && prev_moc !== 1'b1) begin
      if (sb.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_moc @cycle %0d: got MOC=1 required no completion", cyc);
      end else begin
        e = sb.pop_front();
        check("moc_cycle", cyc, e.cyc);
        check("data_out", DATA_OUT, e.dout);
        check("err", {31'd0, ERR}, {31'd0, e.err});
        check("beat", {31'd0, BEAT}, {31'd0, e.beat});
      end
    end
    prev_moc = MOC;
  end

  task automatic wait_moc(input logic val, input string name);
    int i = 0;
    while (MOC !== val && i < 40) begin @(negedge CLK); i++; end
    check(name, {31'd0, MOC}, {31'd0, val});
  endtask

  // Caller is at a negedge with RW/SIGN_EXT/SIZE/ADDR already driven
  task automatic run_beat(input logic rw, input logic sext, input int n, input int ea,
                          input logic [31:0] d, input bit mis, input bit second);
    exp_t e;
    DATA_IN = d;
    MFA = 1;
    if (!mis) begin
      if (rw) exp_dout = model_read(ea, n, sext);
      else mwr(ea, n, d);
    end
    e.cyc = cyc + WS + 2; e.dout = exp_dout; e.err = mis; e.beat = second;
    sb.push_back(e);
    wait_moc(1'b1, "moc_rise");
    MFA = 0;
    DATA_IN = $urandom;
    wait_moc(1'b0, "moc_fall");
  endtask

  task automatic access(input logic rw, input logic sext, input logic [1:0] sz, input int a,
                        input logic [31:0] d0, input logic [31:0] d1);
    int n = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    bit mis;
    int ea;
`ifdef SLS_ALIGN_CHECK_EN
    mis = (a % n) != 0;
    ea  = a;
`else
    mis = 0;
    ea  = a - a % n;
`endif
    RW = rw; SIGN_EXT = sext; SIZE = sz; ADDR = AW'(a);
    run_beat(rw, sext, n, ea, d0, mis, 1'b0);
    if (sz == 2'b11 && !mis) begin
      ADDR = AW'($urandom); SIZE = 2'($urandom);
      run_beat(rw, sext, 4, (ea + 4) % DEPTH, d1, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #2 RST_N = 0;
    #1;
    check("rst_moc", {31'd0, MOC}, 32'd0);
    check("rst_beat", {31'd0, BEAT}, 32'd0);
    check("rst_err", {31'd0, ERR}, 32'd0);
    check("rst_dout", DATA_OUT, 32'd0);
    repeat (3) @(negedge CLK);
    RST_N = 1;
    @(negedge CLK);
    for (int i = 0; i < DEPTH; i += 4) access(1'b0, 1'b0, 2'b10, i, $urandom, 0);
    // Directed: word write/read, byte/half extension, doubleword wrap
    access(1'b0, 1'b0, 2'b10, 'h010, 32'hDEADBEEF, 0);
    access(1'b1, 1'b0, 2'b10, 'h010, 0, 0);
    access(1'b1, 1'b1, 2'b00, 'h010, 0, 0);
    access(1'b1, 1'b0, 2'b01, 'h012, 0, 0);
    access(1'b0, 1'b0, 2'b11, 'h1FC, 32'h11111111, 32'h22222222);
    access(1'b1, 1'b0, 2'b10, 'h1FC, 0, 0);
    access(1'b1, 1'b0, 2'b10, 'h000, 0, 0);
    // Abort in WAIT: MOC must stay low and RAM keep its contents
    RW = 0; SIZE = 2'b10; ADDR = AW'('h010); DATA_IN = 32'h12345678; MFA = 1;
    repeat (2) @(negedge CLK);
    MFA = 0;
    repeat (6) @(negedge CLK);
    check("abort_moc", {31'd0, MOC}, 32'd0);
    access(1'b1, 1'b0, 2'b10, 'h010, 0, 0);
    // Reset in WAIT2 of a doubleword write: beat 1 lands, beat 2 does not
    RW = 0; SIGN_EXT = 0; SIZE = 2'b11; ADDR = AW'('h040);
    run_beat(1'b0, 1'b0, 4, 'h040, 32'hAAAA5555, 1'b0, 1'b0);
    check("gap_beat", {31'd0, BEAT}, 32'd1);
    DATA_IN = 32'h0BADF00D; MFA = 1;
    @(negedge CLK);
    check("wait2_beat", {31'd0, BEAT}, 32'd1);
    #2 RST_N = 0;
    #1;
    check("mid_rst_moc", {31'd0, MOC}, 32'd0);
    check("mid_rst_beat", {31'd0, BEAT}, 32'd0);
    check("mid_rst_err", {31'd0, ERR}, 32'd0);
    check("mid_rst_dout", DATA_OUT, 32'd0);
    exp_dout = 0;
    MFA = 0;
    @(negedge CLK);
    RST_N = 1;
    @(negedge CLK);
    access(1'b1, 1'b0, 2'b10, 'h044, 0, 0);
    access(1'b1, 1'b0, 2'b10, 'h040, 0, 0);
    // Misaligned half read
    access(1'b1, 1'b0, 2'b01, 'h011, 0, 0);
    for (int i = 0; i < 200; i++)
      access(1'($urandom), 1'($urandom), 2'($urandom), int'($urandom_range(DEPTH - 1)), $urandom, $urandom);
    repeat (5) @(negedge CLK);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1);
  end
endmodule
